regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 8x8-bit pipelined register file.
- After reset, sequences the init fill (register k <- k), replacing the regfile's own bulk reset.
- In normal operation, shares the write port between the writeback (WB) stage and a debug/loader requester.
- WB has priority; a starvation guard forces one debug slot by stalling WB for a single cycle.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, registers filled during init (must equal 2**ADDR_W)
- INIT_ON_RESET, 1, 1 = run the init fill after reset; 0 = go straight to RUN
- MAX_WAIT, 4, consecutive blocked debug cycles before a forced slot (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- wb_wr_en  in  1  WB stage write request
- wb_wr_addr  in  ADDR_W  WB destination register
- wb_wr_data  in  DATA_W  WB write data
- dbg_req_valid  in  1  debug write request valid
- dbg_req_addr  in  ADDR_W  debug destination register
- dbg_req_data  in  DATA_W  debug write data
- dbg_req_ready  out  1  debug request accepted this cycle (combinational)
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  ADDR_W  regfile write address (registered)
- rf_wdata  out  DATA_W  regfile write data (registered)
- init_busy  out  1  init fill in progress (registered)
- wb_stall  out  1  WB must hold and re-present its write (registered)

Behaviour:
- Reset (reset==0 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_idx=0, wait_cnt=0.
  - state=INIT if INIT_ON_RESET else RUN.
  - init_busy=INIT_ON_RESET, wb_stall=INIT_ON_RESET.
  - Reset overrides everything, including mid-init or mid-FORCE. Init always restarts at index 0.
- Write latency: the winning request is registered onto rf_* one cycle after acceptance. rf_we=0 in any cycle following no acceptance.
- State INIT:
  - Each cycle registers rf_we=1, rf_waddr=init_idx, rf_wdata=init_idx zero-extended; init_idx increments.
  - After issuing index NUM_REGS-1, go to RUN.
  - init_busy and wb_stall fall in the same cycle the last init write appears on rf_*.
  - Exactly NUM_REGS consecutive rf_we pulses, addresses 0..7 in order.
  - dbg_req_ready=0 throughout; wb_wr_en is ignored (WB is stalled).
- State RUN:
  - dbg_req_ready = dbg_req_valid-independent: 1 when !wb_wr_en.
  - If wb_wr_en: next-cycle rf_* = WB request.
  - Else if dbg_req_valid: next-cycle rf_* = debug request (a transfer).
  - wait_cnt increments each cycle dbg_req_valid && wb_wr_en, saturating at MAX_WAIT.
  - wait_cnt clears on a debug transfer or when dbg_req_valid==0.
  - When wait_cnt reaches MAX_WAIT while dbg_req_valid is still 1, go to FORCE next cycle.
- State FORCE (exactly 1 cycle):
  - wb_stall=1 and dbg_req_ready=1.
  - WB input is ignored that cycle; WB re-presents the same write on the following cycle.
  - If dbg_req_valid: debug write is registered and wait_cnt cleared.
  - If the requester dropped valid: no write.
  - Return to RUN; wb_stall deasserts on the return.
- Same-address collision in RUN: WB wins; the debug request stays pending, with no merge.
- No register is hardwired to zero; address 0 is writable like any other.
- dbg_req_valid may drop without a transfer; no write occurs and wait_cnt clears.
- Addresses are used as-is (ADDR_W bits); no out-of-range case exists.

Test Plan:
- Release reset with INIT_ON_RESET=1:
  - rf_we high for 8 consecutive cycles, (addr,data) = (0,0)..(7,7).
  - init_busy/wb_stall fall with the last write; dbg_req_ready=0 throughout.
- RUN, simultaneous wb(addr 3, 0xA5) and dbg(addr 3, 0x3C):
  - rf writes 3<-0xA5 next cycle; dbg_req_ready=0.
  - With wb idle the following cycle: ready=1, then 3<-0x3C.
- wb_wr_en held high with dbg_req_valid (addr 5, 0x77), MAX_WAIT=4:
  - After 4 blocked cycles, wb_stall=1 for one cycle.
  - 5<-0x77 is written; the WB write re-presented afterwards lands next.
- Assert reset low at init index 4:
  - Writes stop; after release, the fill restarts at (0,0) and completes all 8.
- dbg_req_valid pulsed while wb busy, then dropped before a grant:
  - No debug write occurs; wait_cnt returns to 0; no FORCE.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 8x8 register file: init fill after reset,
// then WB-priority sharing with a debug requester and a starvation guard.
module regfile_write_arbiter #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 3,
  parameter int NUM_REGS      = 8,
  parameter int INIT_ON_RESET = 1,
  parameter int MAX_WAIT      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_wr_en,
  input  logic [ADDR_W-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_wr_data,
  input  logic              dbg_req_valid,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_data,
  output logic              dbg_req_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_busy,
  output logic              wb_stall
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [3:0]        MAXW = 4'(MAX_WAIT);
  localparam logic              INIT = (INIT_ON_RESET != 0);

  logic [1:0]        state;
  logic [ADDR_W-1:0] init_idx;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_nxt;

  assign dbg_req_ready = (state == ST_FORCE) ||
                         ((state == ST_RUN) && !wb_wr_en);

  always_comb begin
    wait_nxt = (wait_cnt == MAXW) ? MAXW : wait_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= INIT ? ST_INIT : ST_RUN;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_idx  <= '0;
      wait_cnt  <= '0;
      init_busy <= INIT;
      wb_stall  <= INIT;
    end else begin
      rf_we <= 1'b0;
      unique case (state)
        ST_INIT: begin
          rf_we    <= 1'b1;
          rf_waddr <= init_idx;
          rf_wdata <= DATA_W'(init_idx);
          init_idx <= init_idx + 1'b1;
          if (init_idx == LAST) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
            wb_stall  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (wb_wr_en) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_wr_addr;
            rf_wdata <= wb_wr_data;
            if (dbg_req_valid) begin
              wait_cnt <= wait_nxt;
              // Guard trips on the edge the count reaches its limit
              if (wait_nxt == MAXW) begin
                state    <= ST_FORCE;
                wb_stall <= 1'b1;
              end
            end else begin
              wait_cnt <= '0;
            end
          end else begin
            if (dbg_req_valid) begin
              rf_we    <= 1'b1;
              rf_waddr <= dbg_req_addr;
              rf_wdata <= dbg_req_data;
            end
            wait_cnt <= '0;
          end
        end
        ST_FORCE: begin
          if (dbg_req_valid) begin
            rf_we    <= 1'b1;
            rf_waddr <= dbg_req_addr;
            rf_wdata <= dbg_req_data;
          end
          wait_cnt <= '0;
          state    <= ST_RUN;
          wb_stall <= 1'b0;
        end
        default: begin
          state    <= ST_RUN;
          wb_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter (default parameters).
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_wr_en;
  logic [2:0] wb_wr_addr;
  logic [7:0] wb_wr_data;
  logic       dbg_req_valid;
  logic [2:0] dbg_req_addr;
  logic [7:0] dbg_req_data;
  logic       dbg_req_ready;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       init_busy;
  logic       wb_stall;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       wb_en;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       dv;
    logic [2:0] da;
    logic [7:0] dd;
    logic       rdy;
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    logic       stall;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  regfile_write_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .wb_wr_en      (wb_wr_en),
    .wb_wr_addr    (wb_wr_addr),
    .wb_wr_data    (wb_wr_data),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_data  (dbg_req_data),
    .dbg_req_ready (dbg_req_ready),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .init_busy     (init_busy),
    .wb_stall      (wb_stall)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic wb_en, input logic [2:0] wa, input logic [7:0] wd,
    input logic dv, input logic [2:0] da, input logic [7:0] dd,
    input logic rdy, input logic we, input logic [2:0] a,
    input logic [7:0] d, input logic stall, input logic busy);
    vec_t v;
    v.wb_en = wb_en; v.wa = wa; v.wd = wd;
    v.dv = dv; v.da = da; v.dd = dd;
    v.rdy = rdy; v.we = we; v.a = a; v.d = d;
    v.stall = stall; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, check ready, then check registered result
  task automatic run_vec(input vec_t v, input string tag);
    wb_wr_en      = v.wb_en;
    wb_wr_addr    = v.wa;
    wb_wr_data    = v.wd;
    dbg_req_valid = v.dv;
    dbg_req_addr  = v.da;
    dbg_req_data  = v.dd;
    #1;
    chk({tag, "_ready"}, int'(dbg_req_ready), int'(v.rdy));
    @(negedge clk);
    chk({tag, "_we"}, int'(rf_we), int'(v.we));
    if (v.we) begin
      chk({tag, "_addr"}, int'(rf_waddr), int'(v.a));
      chk({tag, "_data"}, int'(rf_wdata), int'(v.d));
    end
    chk({tag, "_stall"}, int'(wb_stall), int'(v.stall));
    chk({tag, "_busy"}, int'(init_busy), int'(v.busy));
  endtask

  initial begin
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 3'(7 - k), 8'hFF, 1'b1, 3'(k), 8'hEE,
                       1'b0, 1'b1, 3'(k), 8'(k), k != 7, k != 7));
    // Same-address collision: WB first, debug next when WB idles
    tbl.push_back(mk(1, 3, 8'hA5, 1, 3, 8'h3C, 0, 1, 3, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 3, 8'h3C, 1, 1, 3, 8'h3C, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
    // Starvation guard: four blocked cycles, then a forced slot
    tbl.push_back(mk(1, 1, 8'h11, 1, 5, 8'h77, 0, 1, 1, 8'h11, 0, 0));
    tbl.push_back(mk(1, 2, 8'h22, 1, 5, 8'h77, 0, 1, 2, 8'h22, 0, 0));
    tbl.push_back(mk(1, 3, 8'h33, 1, 5, 8'h77, 0, 1, 3, 8'h33, 0, 0));
    tbl.push_back(mk(1, 4, 8'h44, 1, 5, 8'h77, 0, 1, 4, 8'h44, 1, 0));
    tbl.push_back(mk(1, 6, 8'h66, 1, 5, 8'h77, 1, 1, 5, 8'h77, 0, 0));
    tbl.push_back(mk(1, 6, 8'h66, 0, 0, 8'h00, 0, 1, 6, 8'h66, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
    // Valid dropped before grant: count must clear, no forced slot
    tbl.push_back(mk(1, 0, 8'h10, 1, 7, 8'hEE, 0, 1, 0, 8'h10, 0, 0));
    tbl.push_back(mk(1, 0, 8'h20, 1, 7, 8'hEE, 0, 1, 0, 8'h20, 0, 0));
    tbl.push_back(mk(1, 0, 8'h30, 0, 7, 8'hEE, 0, 1, 0, 8'h30, 0, 0));
    tbl.push_back(mk(1, 1, 8'h50, 1, 7, 8'hEE, 0, 1, 1, 8'h50, 0, 0));
    tbl.push_back(mk(1, 2, 8'h60, 1, 7, 8'hEE, 0, 1, 2, 8'h60, 0, 0));
    tbl.push_back(mk(1, 3, 8'h70, 1, 7, 8'hEE, 0, 1, 3, 8'h70, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 7, 8'hEE, 1, 0, 0, 8'h00, 0, 0));
    // Address 0 is an ordinary writable register
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h5A, 1, 1, 0, 8'h5A, 0, 0));

    reset = 1'b0;
    wb_wr_en = 1'b0; wb_wr_addr = '0; wb_wr_data = '0;
    dbg_req_valid = 1'b0; dbg_req_addr = '0; dbg_req_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_we", int'(rf_we), 0);
    chk("rst_addr", int'(rf_waddr), 0);
    chk("rst_data", int'(rf_wdata), 0);
    chk("rst_busy", int'(init_busy), 1);
    chk("rst_stall", int'(wb_stall), 1);
    chk("rst_ready", int'(dbg_req_ready), 0);

    // Partial fill, then reset at init index 4
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      run_vec(tbl[i], $sformatf("pre%0d", i));
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_we", int'(rf_we), 0);
    chk("midrst_busy", int'(init_busy), 1);
    chk("midrst_stall", int'(wb_stall), 1);
    chk("midrst_addr", int'(rf_waddr), 0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], $sformatf("v%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
